alu_bist: RTL
=============

// Module: alu_bist
// PURPOSE
// Built-in self-test sequencer for the core ALU: the driving end of the ALU's op1/op2/alu_control -> result/flags interface.
// On start it applies N_PATTERNS LFSR operand pairs x N_OPS control codes and captures result/flags after a settle cycle.
// It compacts every response into a rotate-XOR signature and compares the final signature against GOLDEN_SIG.
// Sits beside the ALU in core test mode; the ALU itself stays combinational.
// PARAMETERS
// WIDTH       32            operand/result/signature width (even, >= 8)
// N_OPS       10            control codes applied per pattern: 0 .. N_OPS-1 (N_OPS <= 16)
// N_PATTERNS  8             operand pairs applied
// LFSR_SEED   32'h0000_0001 operand LFSR seed (truncated to WIDTH; must be nonzero)
// SIG_SEED    32'h0000_0000 signature value loaded on start
// GOLDEN_SIG  32'h0000_0000 expected final signature
// PORTS
// clk          in   1      clock, rising edge
// reset        in   1      asynchronous, active-high
// start        in   1      begin a run (sampled in IDLE or DONE)
// abort        in   1      cancel a run in progress
// op1          out  WIDTH  ALU operand A (registered)
// op2          out  WIDTH  ALU operand B (registered)
// alu_control  out  4      ALU op select (registered)
// result       in   WIDTH  ALU result
// flags        in   4      ALU flags
// busy         out  1      run in progress
// done         out  1      run complete; held until next start
// pass         out  1      signature == GOLDEN_SIG; valid while done=1
// signature    out  WIDTH  running/final signature
// BEHAVIOUR
// - Reset (async): state IDLE; op1, op2, alu_control, busy, done, pass and signature all 0; LFSR = LFSR_SEED.
// - FSM: IDLE -> APPLY <-> CAPTURE -> DONE. Each vector costs 2 cycles. Total run = 2*N_OPS*N_PATTERNS cycles.
// - IDLE/DONE + start: load LFSR = LFSR_SEED and signature = SIG_SEED; clear done and pass; set busy=1.
//   Drive vector 0 (op1 = LFSR, op2 = f(LFSR), alu_control = 0); go to APPLY.
// - f(x) = {x[WIDTH/2-1:0], x[WIDTH-1:WIDTH/2]} ^ {WIDTH/2{2'b01}}. This is a half-word rotate XOR 0x5555...
// - APPLY: outputs held stable for the ALU to settle; next edge goes to CAPTURE.
// - CAPTURE edge:
//   signature <= {sig[WIDTH-2:0], sig[WIDTH-1]} ^ result ^ {{WIDTH-4{1'b0}}, flags}.
//   Then present the next vector and return to APPLY.
//   Next vector: alu_control+1; if it was N_OPS-1 it wraps to 0, the LFSR advances one step, and op1/op2 reload.
// - LFSR: Galois right-shift, taps 32'h8020_0003 (truncated), next = (x>>1) ^ (x[0] ? TAPS : 0).
// - Final CAPTURE (last op, last pattern): go to DONE with the final signature update.
//   busy=0, done=1, pass=(updated signature == GOLDEN_SIG); op1, op2, alu_control -> 0.
// - Simultaneous start with abort: abort wins.
// - start while busy: ignored.
// - abort while busy: next edge IDLE; busy=0, done=0, pass=0, ALU outputs 0; signature holds its partial value.
// - abort in IDLE/DONE: no effect.
// - reset mid-run: immediate async return to reset values; no clock needed.
// - signature visible every cycle (partial during run).
// TESTING
// 1 Zero stub ALU (result=0, flags=0), defaults; start pulse at edge k:
//   -> busy=1 after edge k; done=1 and busy=0 after edge k+160.
//   -> signature=0, pass=1.
// 2 Defaults, first vectors:
//   -> op1=32'h0000_0001, op2=32'h5554_5555, alu_control steps 0..9 every 2 cycles.
//   -> 11th vector: op1=32'h8020_0003, op2=32'h0003_8020^32'h5555_5555=32'h5556_D575, alu_control=0.
// 3 N_OPS=1, N_PATTERNS=1, stub result=32'h0000_00F0, flags=4'hA:
//   -> done 2 cycles after start, signature=32'h0000_00FA, pass=0.
// 4 abort asserted at cycle 37 of a run:
//   -> next edge busy=0, done=0, op1/op2/alu_control=0.
//   -> a fresh start yields the same final signature as an uninterrupted run.
// 5 reset pulsed mid-run between clock edges:
//   -> all outputs 0 immediately.
//   -> start after release behaves as test 1.
// 6 start re-pulsed while busy: ignored, run length still 160.
//   start pulsed in DONE: done clears next edge and a new run begins.
//   Against the real ALU, two back-to-back runs must give identical signature.

Source files
------------

// File: rtl/alu_bist.sv
// Built-in self-test sequencer for the core ALU: drives LFSR operand pairs over every
// control code, folds each result/flags response into a rotate-XOR signature and grades it.
module alu_bist #(
    parameter int               WIDTH      = 32,
    parameter int               N_OPS      = 10,
    parameter int               N_PATTERNS = 8,
    parameter logic [WIDTH-1:0] LFSR_SEED  = WIDTH'(32'h0000_0001),
    parameter logic [WIDTH-1:0] SIG_SEED   = WIDTH'(32'h0000_0000),
    parameter logic [WIDTH-1:0] GOLDEN_SIG = WIDTH'(32'h0000_0000)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] op1,
    output logic [WIDTH-1:0] op2,
    output logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] result,
    input  logic [3:0]       flags,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [1:0]       dbg_state
);

    localparam int               HALF     = WIDTH / 2;
    localparam int               PW       = (N_PATTERNS > 1) ? $clog2(N_PATTERNS) : 1;
    localparam logic [WIDTH-1:0] TAPS     = WIDTH'(32'h8020_0003);
    localparam logic [3:0]       LAST_OP  = 4'(N_OPS - 1);
    localparam logic [PW-1:0]    LAST_PAT = PW'(N_PATTERNS - 1);

    typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] lfsr_next;
    logic [WIDTH-1:0] sig_next;
    logic [PW-1:0]    pat;

    assign dbg_state = state;

    // Second operand is a half-word swap of the first with alternating bits flipped.
    function automatic logic [WIDTH-1:0] mix(input logic [WIDTH-1:0] x);
        return {x[HALF-1:0], x[WIDTH-1:HALF]} ^ {HALF{2'b01}};
    endfunction

    always_comb begin
        lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
        sig_next  = {signature[WIDTH-2:0], signature[WIDTH-1]} ^ result
                    ^ {{(WIDTH-4){1'b0}}, flags};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            lfsr        <= LFSR_SEED;
            pat         <= '0;
            op1         <= '0;
            op2         <= '0;
            alu_control <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            signature   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start && !abort) begin
                        state       <= APPLY;
                        lfsr        <= LFSR_SEED;
                        pat         <= '0;
                        signature   <= SIG_SEED;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        busy        <= 1'b1;
                        op1         <= LFSR_SEED;
                        op2         <= mix(LFSR_SEED);
                        alu_control <= '0;
                    end
                end
                APPLY, CAPTURE: begin
                    if (abort) begin
                        // Signature keeps its partial value so a cancelled run can be inspected.
                        state       <= IDLE;
                        busy        <= 1'b0;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        op1         <= '0;
                        op2         <= '0;
                        alu_control <= '0;
                    end else if (state == APPLY) begin
                        state <= CAPTURE;
                    end else begin
                        signature <= sig_next;
                        if (alu_control != LAST_OP) begin
                            alu_control <= alu_control + 4'd1;
                            state       <= APPLY;
                        end else if (pat != LAST_PAT) begin
                            pat         <= pat + 1'b1;
                            lfsr        <= lfsr_next;
                            op1         <= lfsr_next;
                            op2         <= mix(lfsr_next);
                            alu_control <= '0;
                            state       <= APPLY;
                        end else begin
                            state       <= DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            pass        <= (sig_next == GOLDEN_SIG);
                            op1         <= '0;
                            op2         <= '0;
                            alu_control <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
